// File: rtl/seg_cmd_ctrl.sv
// seg_cmd_ctrl: framed UART command decoder driving a 7-segment display.
// A frame is A5, CMD, DATA, CHK (CHK = CMD ^ DATA). Accepted commands update
// the display registers and produce a one-byte response. The segment output
// is gated by a 4-bit PWM duty and a prescaled blink divider.
module seg_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [6:0] segments,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [7:0] HEADER   = 8'hA5;
    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    localparam logic [7:0] CMD_PATTERN = 8'h01;
    localparam logic [7:0] CMD_DUTY    = 8'h02;
    localparam logic [7:0] CMD_BLINK   = 8'h03;
    localparam logic [7:0] CMD_READ    = 8'h04;

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int            TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_data;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic            r_err;

    logic [6:0]      r_pattern;
    logic [3:0]      r_duty;
    logic [7:0]      r_blink_div;
    logic            r_blink_on;
    logic [7:0]      r_tick_cnt;
    logic [7:0]      r_presc;
    logic [3:0]      r_pwm_cnt;
    logic [6:0]      r_seg;

    logic            w_frame_ok;
    logic            w_commit;
    logic            w_wr_pattern;
    logic            w_wr_duty;
    logic            w_wr_blink;
    logic            w_pwm_on;
    logic [7:0]      w_resp_byte;

    // A frame is good when the checksum matches and the command is known.
    assign w_frame_ok   = (rx_data == (r_cmd ^ r_data)) &&
                          (r_cmd >= CMD_PATTERN) && (r_cmd <= CMD_READ);
    assign w_commit     = (r_state == S_CHK) && rx_valid && w_frame_ok;
    assign w_wr_pattern = w_commit && (r_cmd == CMD_PATTERN);
    assign w_wr_duty    = w_commit && (r_cmd == CMD_DUTY);
    assign w_wr_blink   = w_commit && (r_cmd == CMD_BLINK);
    assign w_pwm_on     = (r_pwm_cnt < r_duty);

    // Response byte for the frame completing this cycle (pattern read uses the pre-update value).
    always_comb begin
        // NOTE: assign a default first so no path leaves the output unassigned, which would infer a latch.
        w_resp_byte = RESP_NAK;
        if (w_frame_ok) begin
            if (r_cmd == CMD_READ) begin
                w_resp_byte = {1'b0, r_pattern};
            end else begin
                w_resp_byte = RESP_ACK;
            end
        end
    end

    // Frame FSM: header hunt, byte capture, inter-byte timeout and response handshake.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, matching hardware.
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= 8'h00;
            r_data     <= 8'h00;
            r_to_cnt   <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_to_cnt <= '0;
                    if (rx_valid && (rx_data == HEADER)) begin
                        r_state <= S_CMD;
                    end
                end
                S_CMD, S_DATA, S_CHK: begin
                    if (rx_valid) begin
                        r_to_cnt <= '0;
                        if (r_state == S_CMD) begin
                            r_cmd   <= rx_data;
                            r_state <= S_DATA;
                        end else if (r_state == S_DATA) begin
                            r_data  <= rx_data;
                            r_state <= S_CHK;
                        end else begin
                            r_state    <= S_RESP;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= w_resp_byte;
                            r_err      <= ~w_frame_ok;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        // Abandon the partial frame silently apart from the error pulse.
                        r_to_cnt <= '0;
                        r_state  <= S_IDLE;
                        r_err    <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    // Incoming bytes are dropped here; only the handshake matters.
                    if (r_tx_valid && tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Display configuration registers, written only by a complete, valid frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern   <= 7'h00;
            r_duty      <= 4'hF;
            r_blink_div <= 8'h00;
        end else begin
            if (w_wr_pattern) r_pattern   <= r_data[6:0];
            if (w_wr_duty)    r_duty      <= r_data[3:0];
            if (w_wr_blink)   r_blink_div <= r_data;
        end
    end

    // PWM counter, 256-cycle prescaler and blink phase; a blink_div write restarts the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt  <= 4'h0;
            r_presc    <= 8'h00;
            r_tick_cnt <= 8'h00;
            r_blink_on <= 1'b1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'h1;
            r_presc   <= r_presc + 8'h01;
            if (w_wr_blink || (r_blink_div == 8'h00)) begin
                r_tick_cnt <= 8'h00;
                r_blink_on <= 1'b1;
            end else if (r_presc == 8'hFF) begin
                if ((r_tick_cnt + 8'h01) == r_blink_div) begin
                    r_tick_cnt <= 8'h00;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 8'h01;
                end
            end
        end
    end

    // Registered segment drive: pattern gated by PWM and blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'h00;
        end else begin
            r_seg <= r_pattern & {7{w_pwm_on & r_blink_on}};
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign segments = r_seg;
    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;

endmodule

// File: tb/tb_seg_cmd_ctrl.sv
// Testbench for seg_cmd_ctrl: directed and randomized frames checked against
// an arithmetic model of the display registers and segment gating.
module tb_seg_cmd_ctrl;

    localparam int T = 64;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [6:0] segments;
    logic       busy;
    logic       err;

    seg_cmd_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .segments (segments),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the free-running counters are functions of it.
    int unsigned edge_cnt = 0;
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference model of the configuration registers.
    int          m_pattern;
    int          m_duty;
    int          m_div;
    int unsigned m_blink_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Segments seen after edge e reflect configuration and counters after edge e-1.
    function automatic int exp_seg(input int unsigned e);
        int unsigned p;
        int unsigned n;
        bit          pwm_on;
        bit          blink_on;
        if (e == 0) return 0;
        p      = e - 1;
        pwm_on = int'(p % 16) < m_duty;
        if (m_div == 0) begin
            blink_on = 1'b1;
        end else begin
            n        = p / 256 - m_blink_edge / 256;
            blink_on = ((n / int'(m_div)) % 2) == 0;
        end
        return (pwm_on && blink_on) ? m_pattern : 0;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic model_reset();
        m_pattern    = 0;
        m_duty       = 15;
        m_div        = 0;
        m_blink_edge = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (cycles) step();
        check("rst_segments", 32'(segments), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data",  32'(tx_data),  32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_err",      32'(err),      32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic seg_window(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("segments", 32'(segments), 32'(exp_seg(edge_cnt)));
        end
    endtask

    // Full frame with optional inter-byte gap and delayed tx_ready (optionally with rx noise).
    task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk,
                         input int gap, input int ready_delay, input bit junk);
        bit         ok;
        logic [7:0] resp;
        ok = (chk == (cmd ^ data)) && (cmd >= 8'd1) && (cmd <= 8'd4);
        if (!ok)             resp = 8'h15;
        else if (cmd == 8'd4) resp = {1'b0, 7'(m_pattern)};
        else                 resp = 8'h06;
        tx_ready = (ready_delay == 0);
        send_byte(8'hA5);
        check("busy_after_header", 32'(busy), 32'h1);
        idle(gap);
        send_byte(cmd);
        idle(gap);
        send_byte(data);
        idle(gap);
        send_byte(chk);
        check("resp_tx_valid", 32'(tx_valid), 32'h1);
        check("resp_tx_data",  32'(tx_data),  32'(resp));
        check("resp_err",      32'(err),      32'(!ok));
        check("resp_busy",     32'(busy),     32'h1);
        if (ok) begin
            case (cmd)
                8'd1: m_pattern = int'(data[6:0]);
                8'd2: m_duty    = int'(data[3:0]);
                8'd3: begin
                    m_div        = int'(data);
                    m_blink_edge = edge_cnt;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < ready_delay; i++) begin
            if (junk) begin
                rx_valid = 1'($urandom_range(0, 1));
                rx_data  = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'($urandom);
            end
            step();
            check("hold_tx_valid", 32'(tx_valid), 32'h1);
            check("hold_tx_data",  32'(tx_data),  32'(resp));
            check("hold_err",      32'(err),      32'h0);
            check("hold_busy",     32'(busy),     32'h1);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        step();
        check("done_tx_valid", 32'(tx_valid), 32'h0);
        check("done_busy",     32'(busy),     32'h0);
        check("done_err",      32'(err),      32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c;
        logic [7:0] d;
        logic [7:0] k;

        model_reset();
        do_reset(3);
        seg_window(5);

        // Pattern write, full brightness.
        frame(8'h01, 8'h7F, 8'h7E, 0, 0, 1'b0);
        seg_window(32);

        // Bad checksum leaves pattern alone; read back returns it.
        frame(8'h01, 8'h3F, 8'h00, 0, 0, 1'b0);
        frame(8'h04, 8'h00, 8'h04, 0, 0, 1'b0);
        seg_window(8);

        // Unknown commands, one with a checksum that matches.
        frame(8'h05, 8'h12, 8'h17, 1, 0, 1'b0);
        frame(8'h00, 8'h00, 8'h00, 0, 0, 1'b0);

        // Longest legal gap between bytes.
        frame(8'h02, 8'h07, 8'h05, T - 1, 0, 1'b0);
        seg_window(32);

        // Timeout after exactly T idle cycles.
        tx_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(T - 1);
        check("to_busy_before", 32'(busy), 32'h1);
        check("to_err_before",  32'(err),  32'h0);
        step();
        check("to_err",      32'(err),      32'h1);
        check("to_busy",     32'(busy),     32'h0);
        check("to_tx_valid", 32'(tx_valid), 32'h0);
        step();
        check("to_err_pulse", 32'(err), 32'h0);
        frame(8'h02, 8'h0F, 8'h0D, 0, 0, 1'b0);
        frame(8'h04, 8'h00, 8'h04, 0, 0, 1'b0);

        // Stalled response with bytes arriving during RESP.
        frame(8'h01, 8'h5A, 8'h5B, 0, 20, 1'b1);
        seg_window(16);

        // Blink divider 1, then duty 0.
        frame(8'h01, 8'h7F, 8'h7E, 0, 0, 1'b0);
        frame(8'h03, 8'h01, 8'h02, 0, 0, 1'b0);
        seg_window(600);
        frame(8'h02, 8'h00, 8'h02, 0, 0, 1'b0);
        seg_window(40);

        // Non-header bytes in IDLE are ignored.
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            if (d == 8'hA5) d = 8'h5A;
            send_byte(d);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_err",  32'(err),  32'h0);
        end

        // Randomized frames.
        for (int i = 0; i < 16; i++) begin
            c = 8'($urandom_range(0, 5));
            d = 8'($urandom);
            k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ d);
            frame(c, d, k, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 1'b1);
            seg_window(24);
        end

        // Reset after the DATA byte; trailing CHK must be ignored.
        frame(8'h01, 8'h33, 8'h32, 0, 0, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h55);
        do_reset(1);
        send_byte(8'h54);
        check("rst_frame_busy",     32'(busy),     32'h0);
        check("rst_frame_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_frame_err",      32'(err),      32'h0);
        frame(8'h04, 8'h00, 8'h04, 0, 0, 1'b0);

        // Reset while a response is pending.
        tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h10);
        check("pend_tx_valid", 32'(tx_valid), 32'h1);
        do_reset(1);
        tx_ready = 1'b1;
        step();
        check("after_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("after_rst_busy",     32'(busy),     32'h0);
        frame(8'h04, 8'h00, 8'h04, 0, 0, 1'b0);
        frame(8'h01, 8'h2A, 8'h2B, 0, 0, 1'b0);
        seg_window(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_cmd_ctrl.md
SEG_CMD_CTRL -- requirements
Module: seg_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between bytes of one frame.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 rx_data  in  8  byte from UART receiver.
REQ-005 rx_valid  in  1  one-cycle strobe; rx_data valid.
REQ-006 tx_data  out  8  response byte to UART transmitter.
REQ-007 tx_valid  out  1  response valid; held until tx_ready.
REQ-008 tx_ready  in  1  transmitter accepts tx_data when high with tx_valid.
REQ-009 segments  out  7  7-segment drive, active-high, after PWM/blink gating.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 err  out  1  one-cycle pulse on frame error or timeout.

Function
REQ-012 Frame: header 0xA5, CMD byte, DATA byte, CHK byte; CHK SHALL equal CMD ^ DATA.
REQ-013 FSM states IDLE, CMD, DATA, CHK, RESP; each byte advances state on its rx_valid cycle.
REQ-014 IDLE: rx_valid with 0xA5 -> CMD; any other byte ignored, no err.
REQ-015 CMD/DATA: byte latched, -> next state; CHK: byte compared, -> RESP.
REQ-016 On the cycle after CHK byte (N+1): registers updated and tx_valid=1 with response byte.
REQ-017 CMD 0x01: pattern <= DATA[6:0]; response 0x06.
REQ-018 CMD 0x02: duty <= DATA[3:0]; response 0x06.
REQ-019 CMD 0x03: blink_div <= DATA; response 0x06.
REQ-020 CMD 0x04: no register change; response {1'b0, pattern}.
REQ-021 Bad CHK or unknown CMD: no register change, response 0x15, err pulse at N+1.
REQ-022 RESP: tx_valid and tx_data held stable until tx_valid&tx_ready; -> IDLE next cycle.
REQ-023 rx_valid in RESP SHALL be dropped (no effect, no err); 0xA5 during CMD/DATA/CHK treated as data.
REQ-024 Timeout counter resets on each accepted byte; in CMD/DATA/CHK, after TIMEOUT_CYCLES cycles without rx_valid -> IDLE, err pulse, no response, no register change.
REQ-025 PWM: 4-bit free-running counter pwm_cnt; pwm_on = (pwm_cnt < duty); duty 0 = always off.
REQ-026 Blink: 8-bit prescaler ticks every 256 cycles; tick counter counts to blink_div, then toggles blink_on and clears; blink_div 0 -> blink_on forced 1, counter held at 0.
REQ-027 Writing blink_div SHALL clear tick counter and set blink_on=1.
REQ-028 segments = pattern & {7{pwm_on & blink_on}}, registered (one-cycle latency from gating terms).

Reset
REQ-029 rst SHALL take priority over all inputs, including mid-frame and mid-RESP.
REQ-030 Reset values: state IDLE, pattern 0, duty 4'hF, blink_div 0, blink_on 1, pwm_cnt 0, prescaler 0, timeout counter 0.
REQ-031 Reset outputs: segments 0, tx_valid 0, tx_data 0x00, busy 0, err 0.
REQ-032 rst asserted during RESP SHALL drop the pending response; no register update from partial frames.

Verification
REQ-033 Frame A5 01 7F 7E, tx_ready=1 -> tx_data 0x06 at N+1; pattern 0x7F; segments 0x7F for 15 of every 16 cycles.
REQ-034 Frame A5 01 3F 00 -> tx_data 0x15, err pulse, pattern unchanged; then A5 04 00 04 -> tx_data equals prior pattern.
REQ-035 A5 then 01, then TIMEOUT_CYCLES idle cycles -> err pulse, busy 0, no tx_valid; next valid frame accepted normally.
REQ-036 Valid frame with tx_ready=0 for 20 cycles, rx bytes sent meanwhile -> tx_valid/tx_data stable 20 cycles, rx bytes ignored, IDLE one cycle after tx_ready.
REQ-037 A5 03 01 02 (blink_div 1), pattern 0x7F, duty F -> segments toggle between gated-on and 0 every 256 cycles; A5 02 00 02 -> segments constant 0.
REQ-038 rst pulsed after DATA byte, then CHK byte -> no response, registers at reset values, busy 0.
